div: RTL



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 25 ++
 rtl/div.sv | 116 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state codes and constants for the divider
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic RstEnable         = 1'b1;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division iteration
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] dvd,
    input  logic [DATA_W-1:0] dvs,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] dvd_next,
    output logic              q_bit
);

    logic [DATA_W:0] trial;
    logic [DATA_W:0] diff;

    // trial < 2*dvs always holds, so the top bit of the W+1-bit difference is an exact sign
    always_comb begin
        trial    = {rem, dvd[DATA_W-1]};
        diff     = trial - {1'b0, dvs};
        q_bit    = ~diff[DATA_W];
        rem_next = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        dvd_next = {dvd[DATA_W-2:0], q_bit};
    end

endmodule

// File: rtl/div.sv
// rtl/div.sv - multi-cycle restoring integer divider for the EX stage
import div_pkg::*;

module div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic              sgn;
    logic              s1;
    logic              s2;

    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] dvd_next;
    logic              q_bit;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem),
        .dvd      (dvd),
        .dvs      (dvs),
        .rem_next (rem_next),
        .dvd_next (dvd_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        mag1  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        q_fix = (sgn && (s1 ^ s2)) ? -dvd : dvd;
        r_fix = (sgn && s1) ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            sgn      <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
        end else begin
            case (state)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == '0) begin
                            // dividend kept raw so it can be returned as the remainder
                            state <= DivByZero;
                            dvd   <= opdata1_i;
                        end else begin
                            state <= DivOn;
                            cnt   <= '0;
                            rem   <= '0;
                            dvd   <= mag1;
                            dvs   <= mag2;
                            sgn   <= signed_div_i;
                            s1    <= opdata1_i[DATA_W-1];
                            s2    <= opdata2_i[DATA_W-1];
                        end
                    end
                end
                DivByZero: begin
                    state    <= DivEnd;
                    ready_o  <= DivResultReady;
                    result_o <= {dvd, {DATA_W{1'b1}}};
                end
                DivOn: begin
                    if (annul_i || start_i == DivStop) begin
                        state <= DivFree;
                    end else if (cnt != CNT_W'(DATA_W)) begin
                        rem <= rem_next;
                        dvd <= dvd_next;
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state    <= DivEnd;
                        ready_o  <= DivResultReady;
                        result_o <= {r_fix, q_fix};
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule
